// File: rtl/algo_t1_1r1w_bank_resp_pkg.sv
// Shared types for the t1 physical-bank responder: FSM states, read-pipe record, latency bounds.
package algo_t1_pkg;

   typedef enum logic {
      T1_INIT = 1'b0,
      T1_RUN  = 1'b1
   } t1_state_t;

   localparam int MAX_SRAM_DELAY = 4;

   // Widest physical row the read pipe can carry; narrower banks zero-pad.
   localparam int T1_MAX_WDTH = 128;

   typedef struct packed {
      logic                   vld;
      logic                   coll;
      logic [T1_MAX_WDTH-1:0] data;
   } rd_pipe_t;

   function automatic int clamp_delay(int d);
      if (d < 1) return 1;
      if (d > MAX_SRAM_DELAY) return MAX_SRAM_DELAY;
      return d;
   endfunction

endpackage

// File: rtl/algo_t1_1r1w_bank_resp_if.sv
// t1 bank port bundle: masked write port A, latency read port B, plus status flags.
interface algo_t1_1r1w_bank_resp_if #(
   parameter int PHYWDTH = 128,
   parameter int BITSROW = 12
);

   logic               ready;
   logic               t1_writeA;
   logic [BITSROW-1:0] t1_addrA;
   logic [PHYWDTH-1:0] t1_dinA;
   logic [PHYWDTH-1:0] t1_bwA;
   logic               t1_readB;
   logic [BITSROW-1:0] t1_addrB;
   logic [PHYWDTH-1:0] t1_doutB;
   logic               t1_vldB;
   logic               t1_collB;
   logic               t1_aerr;

   modport master (
      output t1_writeA, t1_addrA, t1_dinA, t1_bwA, t1_readB, t1_addrB,
      input  ready, t1_doutB, t1_vldB, t1_collB, t1_aerr
   );

   modport slave (
      input  t1_writeA, t1_addrA, t1_dinA, t1_bwA, t1_readB, t1_addrB,
      output ready, t1_doutB, t1_vldB, t1_collB, t1_aerr
   );

endinterface

// File: rtl/algo_t1_1r1w_bank_resp_rd_pipe.sv
// Fixed-depth shift pipe carrying read results; async active-low reset flushes every stage.
module algo_t1_rd_pipe
   import algo_t1_pkg::*;
#(
   parameter int DEPTH = 1
) (
   input  logic     clk,
   input  logic     rst,
   input  rd_pipe_t in_d,
   output rd_pipe_t out_q
);

   rd_pipe_t stage [DEPTH];

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         for (int i = 0; i < DEPTH; i++) stage[i] <= '0;
      end else begin
         stage[0] <= in_d;
         for (int i = 1; i < DEPTH; i++) stage[i] <= stage[i-1];
      end
   end

   assign out_q = stage[DEPTH-1];

endmodule

// File: rtl/algo_t1_1r1w_bank_resp.sv
// One physical t1 bank: init sweep after reset, masked write on A, pipelined read on B,
// with read-first collision and address/readiness error flags.
module algo_t1_1r1w_bank_resp
   import algo_t1_pkg::*;
#(
   parameter int PHYWDTH    = 128,
   parameter int NUMSROW    = 4096,
   parameter int BITSROW    = 12,
   parameter int SRAM_DELAY = 1,
   parameter bit INITVAL    = 1'b0
) (
   input logic                      clk,
   input logic                      rst,
   algo_t1_1r1w_bank_resp_if.slave  bus
);

   localparam int                 PIPE_DEPTH = clamp_delay(SRAM_DELAY);
   localparam logic [BITSROW-1:0] LAST_ROW   = BITSROW'(NUMSROW - 1);

   t1_state_t          state;
   t1_state_t          state_nxt;
   logic               ready;
   logic [BITSROW-1:0] cnt;
   logic [PHYWDTH-1:0] mem [NUMSROW];
   logic               a_ok;
   logic               b_ok;
   logic               wr_en;
   logic               rd_en;
   logic               aerr_nxt;
   logic               aerr_q;
   logic [PHYWDTH-1:0] rd_data;
   logic [PHYWDTH-1:0] dout_hold;
   rd_pipe_t           pipe_in;
   rd_pipe_t           pipe_out;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) state <= T1_INIT;
      else      state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      if (state == T1_INIT && cnt == LAST_ROW) state_nxt = T1_RUN;
   end

   always_comb begin
      ready = (state == T1_RUN);
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst)                 cnt <= '0;
      else if (state == T1_INIT) cnt <= cnt + 1'b1;
   end

   // Strobes are only honoured in RUN; anything else is reported through aerr.
   always_comb begin
      a_ok     = int'(bus.t1_addrA) < NUMSROW;
      b_ok     = int'(bus.t1_addrB) < NUMSROW;
      wr_en    = ready && bus.t1_writeA && a_ok;
      rd_en    = ready && bus.t1_readB && b_ok;
      aerr_nxt = (bus.t1_writeA && (!ready || !a_ok)) ||
                 (bus.t1_readB  && (!ready || !b_ok));
   end

   // Combinational array read before the edge gives read-first collision semantics.
   always_comb begin
      rd_data = '0;
      if (rd_en) rd_data = mem[bus.t1_addrB];
   end

   always_ff @(posedge clk) begin
      if (!ready)
         mem[cnt] <= {PHYWDTH{INITVAL}};
      else if (wr_en)
         mem[bus.t1_addrA] <= (mem[bus.t1_addrA] & ~bus.t1_bwA) | (bus.t1_dinA & bus.t1_bwA);
   end

   always_comb begin
      pipe_in      = '0;
      pipe_in.vld  = ready && bus.t1_readB;
      pipe_in.coll = rd_en && wr_en && (bus.t1_addrA == bus.t1_addrB);
      pipe_in.data = T1_MAX_WDTH'(rd_data);
   end

   algo_t1_rd_pipe #(
      .DEPTH (PIPE_DEPTH)
   ) u_rd_pipe (
      .clk   (clk),
      .rst   (rst),
      .in_d  (pipe_in),
      .out_q (pipe_out)
   );

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         aerr_q    <= 1'b0;
         dout_hold <= '0;
      end else begin
         aerr_q <= aerr_nxt;
         if (pipe_out.vld) dout_hold <= pipe_out.data[PHYWDTH-1:0];
      end
   end

   assign bus.ready    = ready;
   assign bus.t1_doutB = pipe_out.vld ? pipe_out.data[PHYWDTH-1:0] : dout_hold;
   assign bus.t1_vldB  = pipe_out.vld;
   assign bus.t1_collB = pipe_out.coll;
   assign bus.t1_aerr  = aerr_q;

endmodule

// File: tb/tb_algo_t1_1r1w_bank_resp.sv
// Bench for the t1 bank responder: a 16-row and a 12-row bank see identical traffic and are
// checked every cycle against a behavioural model, plus directed vector table and sequences.
module tb_algo_t1_1r1w_bank_resp;

   localparam int W  = 128;
   localparam int BR = 4;
   localparam int D  = 2;

   typedef logic [W-1:0] word_t;

   localparam word_t ONES = '1;
   localparam word_t LO64 = {64'h0, {64{1'b1}}};
   localparam word_t PA5  = {16{8'hA5}};

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   logic          drv_writeA = 1'b0;
   logic [BR-1:0] drv_addrA  = '0;
   word_t         drv_dinA   = '0;
   word_t         drv_bwA    = '0;
   logic          drv_readB  = 1'b0;
   logic [BR-1:0] drv_addrB  = '0;

   algo_t1_1r1w_bank_resp_if #(.PHYWDTH(W), .BITSROW(BR)) bus16 ();
   algo_t1_1r1w_bank_resp_if #(.PHYWDTH(W), .BITSROW(BR)) bus12 ();

   assign bus16.t1_writeA = drv_writeA;
   assign bus16.t1_addrA  = drv_addrA;
   assign bus16.t1_dinA   = drv_dinA;
   assign bus16.t1_bwA    = drv_bwA;
   assign bus16.t1_readB  = drv_readB;
   assign bus16.t1_addrB  = drv_addrB;
   assign bus12.t1_writeA = drv_writeA;
   assign bus12.t1_addrA  = drv_addrA;
   assign bus12.t1_dinA   = drv_dinA;
   assign bus12.t1_bwA    = drv_bwA;
   assign bus12.t1_readB  = drv_readB;
   assign bus12.t1_addrB  = drv_addrB;

   algo_t1_1r1w_bank_resp #(
      .PHYWDTH(W), .NUMSROW(16), .BITSROW(BR), .SRAM_DELAY(D), .INITVAL(1'b0)
   ) dut16 (
      .clk (clk),
      .rst (rst),
      .bus (bus16.slave)
   );

   algo_t1_1r1w_bank_resp #(
      .PHYWDTH(W), .NUMSROW(12), .BITSROW(BR), .SRAM_DELAY(D), .INITVAL(1'b0)
   ) dut12 (
      .clk (clk),
      .rst (rst),
      .bus (bus12.slave)
   );

   int compared   = 0;
   int mismatched = 0;

   // Reference model: per-bank row contents and results scheduled by the edge they are due on.
   word_t mem_m  [2][16];
   bit    ready_m[2];
   bit    aerr_m [2];
   bit    vld_m  [2];
   bit    coll_m [2];
   word_t last_m [2];
   bit    pv     [2][8];
   bit    pc     [2][8];
   word_t pd     [2][8];
   int    edges;

   function automatic int rows_of(int d);
      return (d == 0) ? 16 : 12;
   endfunction

   task automatic model_reset();
      edges = 0;
      for (int d = 0; d < 2; d++) begin
         ready_m[d] = 1'b0;
         aerr_m[d]  = 1'b0;
         vld_m[d]   = 1'b0;
         coll_m[d]  = 1'b0;
         last_m[d]  = '0;
         for (int s = 0; s < 8; s++) begin
            pv[d][s] = 1'b0;
            pc[d][s] = 1'b0;
            pd[d][s] = '0;
         end
         for (int r = 0; r < 16; r++) mem_m[d][r] = '0;
      end
   endtask

   task automatic model_edge();
      int e;
      e = edges + 1;
      for (int d = 0; d < 2; d++) begin
         int n;
         int slot;
         bit a_ok;
         bit b_ok;
         bit acc;
         n    = rows_of(d);
         a_ok = int'(drv_addrA) < n;
         b_ok = int'(drv_addrB) < n;
         acc  = ready_m[d];
         aerr_m[d] = (drv_writeA && (!acc || !a_ok)) || (drv_readB && (!acc || !b_ok));
         if (acc && drv_readB) begin
            slot = (e + D - 1) % 8;
            pv[d][slot] = 1'b1;
            pd[d][slot] = b_ok ? mem_m[d][drv_addrB] : '0;
            pc[d][slot] = drv_writeA && a_ok && b_ok && (drv_addrA == drv_addrB);
         end
         if (acc && drv_writeA && a_ok) begin
            for (int b = 0; b < W; b++)
               if (drv_bwA[b]) mem_m[d][drv_addrA][b] = drv_dinA[b];
         end
         slot = e % 8;
         vld_m[d]  = pv[d][slot];
         coll_m[d] = pv[d][slot] ? pc[d][slot] : 1'b0;
         if (pv[d][slot]) last_m[d] = pd[d][slot];
         pv[d][slot] = 1'b0;
         ready_m[d]  = (e >= n);
      end
      edges = e;
   endtask

   task automatic check_output(string tag, string what, word_t act, word_t exp);
      compared++;
      if (act !== exp) begin
         mismatched++;
         $display("[TB] FAIL %s %s: got %h, expected %h", tag, what, act, exp);
      end
   endtask

   task automatic check_all(string tag);
      check_output(tag, "ready16", W'(bus16.ready),    W'(ready_m[0]));
      check_output(tag, "vld16",   W'(bus16.t1_vldB),  W'(vld_m[0]));
      check_output(tag, "coll16",  W'(bus16.t1_collB), W'(coll_m[0]));
      check_output(tag, "aerr16",  W'(bus16.t1_aerr),  W'(aerr_m[0]));
      check_output(tag, "dout16",  bus16.t1_doutB,     last_m[0]);
      check_output(tag, "ready12", W'(bus12.ready),    W'(ready_m[1]));
      check_output(tag, "vld12",   W'(bus12.t1_vldB),  W'(vld_m[1]));
      check_output(tag, "coll12",  W'(bus12.t1_collB), W'(coll_m[1]));
      check_output(tag, "aerr12",  W'(bus12.t1_aerr),  W'(aerr_m[1]));
      check_output(tag, "dout12",  bus12.t1_doutB,     last_m[1]);
   endtask

   task automatic apply_stimulus(input bit wr, input int aa, input word_t din, input word_t bw,
                                 input bit rd, input int ab);
      drv_writeA = wr;
      drv_addrA  = BR'(aa);
      drv_dinA   = din;
      drv_bwA    = bw;
      drv_readB  = rd;
      drv_addrB  = BR'(ab);
   endtask

   task automatic idle();
      apply_stimulus(1'b0, 0, '0, '0, 1'b0, 0);
   endtask

   task automatic cycle(string tag);
      @(posedge clk);
      model_edge();
      #1;
      check_all(tag);
   endtask

   typedef struct {
      bit    wr;
      int    aa;
      word_t din;
      word_t bw;
      bit    rd;
      int    ab;
      bit    exp_vld;
      word_t exp_dout16;
      bit    exp_coll16;
      word_t exp_dout12;
      bit    exp_aerr12;
   } vec_t;

   function automatic vec_t mk(bit wr, int aa, word_t din, word_t bw, bit rd, int ab,
                               bit ev, word_t ed16, bit ec16, word_t ed12, bit ea12);
      vec_t v;
      v.wr = wr; v.aa = aa; v.din = din; v.bw = bw; v.rd = rd; v.ab = ab;
      v.exp_vld = ev; v.exp_dout16 = ed16; v.exp_coll16 = ec16;
      v.exp_dout12 = ed12; v.exp_aerr12 = ea12;
      return v;
   endfunction

   vec_t vecs [16];

   initial begin
      int stale;
      word_t rnd;
      word_t rbw;

      // Directed vectors: masked write, no-op write, collision, out-of-range and aliasing rows.
      vecs[0]  = mk(1, 5,  ONES, LO64, 0, 0,  0, '0,   0, '0,   0);
      vecs[1]  = mk(1, 5,  '0,   '0,   0, 0,  0, '0,   0, '0,   0);
      vecs[2]  = mk(0, 0,  '0,   '0,   1, 5,  0, '0,   0, '0,   0);
      vecs[3]  = mk(0, 0,  '0,   '0,   0, 0,  1, LO64, 0, LO64, 0);
      vecs[4]  = mk(0, 0,  '0,   '0,   0, 0,  0, LO64, 0, LO64, 0);
      vecs[5]  = mk(1, 3,  PA5,  ONES, 1, 3,  0, LO64, 0, LO64, 0);
      vecs[6]  = mk(0, 0,  '0,   '0,   1, 3,  1, '0,   1, '0,   0);
      vecs[7]  = mk(0, 0,  '0,   '0,   0, 0,  1, PA5,  0, PA5,  0);
      vecs[8]  = mk(1, 14, ONES, ONES, 1, 14, 0, PA5,  0, PA5,  1);
      vecs[9]  = mk(0, 0,  '0,   '0,   0, 0,  1, '0,   1, '0,   0);
      vecs[10] = mk(0, 0,  '0,   '0,   1, 14, 0, '0,   0, '0,   1);
      vecs[11] = mk(0, 0,  '0,   '0,   0, 0,  1, ONES, 0, '0,   0);
      vecs[12] = mk(0, 0,  '0,   '0,   1, 2,  0, ONES, 0, '0,   0);
      vecs[13] = mk(0, 0,  '0,   '0,   1, 6,  1, '0,   0, '0,   0);
      vecs[14] = mk(0, 0,  '0,   '0,   0, 0,  1, '0,   0, '0,   0);
      vecs[15] = mk(0, 0,  '0,   '0,   0, 0,  0, '0,   0, '0,   0);

      // Power-on reset, then the init sweep with one illegal strobe in the middle of it.
      #2 rst = 1'b0;
      model_reset();
      #1 check_all("reset");
      repeat (2) begin
         @(posedge clk);
         #1 check_all("reset_hold");
      end
      rst = 1'b1;
      for (int c = 1; c <= 16; c++) begin
         if (c == 3) apply_stimulus(1'b1, 0, ONES, ONES, 1'b1, 1);
         else        idle();
         cycle("init");
         check_output("init", "ready_count", W'(bus16.ready), W'(c >= 16));
         if (c == 3) check_output("init", "aerr_in_init", W'(bus16.t1_aerr), W'(1));
      end

      for (int j = 0; j < 18; j++) begin
         if (j < 16) apply_stimulus(1'b0, 0, '0, '0, 1'b1, j);
         else        idle();
         cycle("sweep");
         if (j >= 1 && j <= 16) begin
            check_output("sweep", "vld", W'(bus16.t1_vldB), W'(1));
            check_output("sweep", "zero_row", bus16.t1_doutB, '0);
         end
      end

      for (int i = 0; i < 16; i++) begin
         apply_stimulus(vecs[i].wr, vecs[i].aa, vecs[i].din, vecs[i].bw, vecs[i].rd, vecs[i].ab);
         cycle("vec");
         check_output("vec", $sformatf("vld16[%0d]", i),  W'(bus16.t1_vldB),  W'(vecs[i].exp_vld));
         check_output("vec", $sformatf("vld12[%0d]", i),  W'(bus12.t1_vldB),  W'(vecs[i].exp_vld));
         check_output("vec", $sformatf("dout16[%0d]", i), bus16.t1_doutB,     vecs[i].exp_dout16);
         check_output("vec", $sformatf("coll16[%0d]", i), W'(bus16.t1_collB), W'(vecs[i].exp_coll16));
         check_output("vec", $sformatf("dout12[%0d]", i), bus12.t1_doutB,     vecs[i].exp_dout12);
         check_output("vec", $sformatf("aerr12[%0d]", i), W'(bus12.t1_aerr),  W'(vecs[i].exp_aerr12));
      end

      // Back-to-back reads of preloaded rows must stream out one per cycle, in order.
      for (int i = 0; i < 8; i++) begin
         apply_stimulus(1'b1, i, W'(i), ONES, 1'b0, 0);
         cycle("preload");
      end
      for (int j = 0; j < 10; j++) begin
         if (j < 8) apply_stimulus(1'b0, 0, '0, '0, 1'b1, j);
         else       idle();
         cycle("stream");
         if (j >= 1 && j <= 8) begin
            check_output("stream", "vld", W'(bus16.t1_vldB), W'(1));
            check_output("stream", "dout", bus16.t1_doutB, W'(j - 1));
         end else begin
            check_output("stream", "vld_idle", W'(bus16.t1_vldB), W'(0));
         end
      end

      // Reset with reads still in the pipe: outputs clear at once and nothing stale emerges.
      apply_stimulus(1'b0, 0, '0, '0, 1'b1, 1);
      cycle("inflight");
      apply_stimulus(1'b0, 0, '0, '0, 1'b1, 2);
      cycle("inflight");
      idle();
      rst = 1'b0;
      model_reset();
      #1 check_all("rst_async");
      repeat (3) begin
         @(posedge clk);
         #1 check_all("rst_hold");
      end
      rst = 1'b1;
      stale = 0;
      for (int c = 1; c <= 20; c++) begin
         cycle("post_rst");
         if (bus16.t1_vldB || bus12.t1_vldB) stale++;
         if (c == 15 || c == 16)
            check_output("post_rst", "ready_again", W'(bus16.ready), W'(c == 16));
      end
      check_output("post_rst", "stale_vld", W'(stale), '0);

      // Randomised traffic over the full 4-bit address space on both banks.
      for (int k = 0; k < 400; k++) begin
         rnd = {$urandom, $urandom, $urandom, $urandom};
         case ($urandom_range(0, 3))
            0:       rbw = '0;
            1:       rbw = ONES;
            default: rbw = {$urandom, $urandom, $urandom, $urandom};
         endcase
         apply_stimulus(1'($urandom_range(0, 1)), int'($urandom_range(0, 15)), rnd, rbw,
                        1'($urandom_range(0, 1)), int'($urandom_range(0, 15)));
         cycle("random");
      end
      idle();
      repeat (4) cycle("drain");

      $display("[TB] *** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
